// File: rtl/seg_scan_capture.sv
// seg_scan_capture: samples a multiplexed 6-digit 7-segment scan bus, waits
// for each digit slot to settle, decodes it back to BCD and reassembles the
// six digits into a frame. Flags bad patterns, multi-hot enables and a
// frozen scan.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no digit enabled, waiting for a one-hot enable
// ST_SETTLE | one-hot enable seen, counting identical samples
// ST_HOLD   | slot captured, waiting for enable or segments to change
// ST_ERR    | multi-hot enable, waiting for it to become legal again
module seg_scan_capture #(
    parameter int unsigned SETTLE      = 4,
    parameter int unsigned TIMEOUT     = 1000000,
    parameter bit          ENB_ACT_LOW = 1'b0,
    parameter bit          SEG_ACT_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic        o_valid,
    output logic        o_err,
    output logic        o_stall
);

    localparam logic [3:0]  SETTLE_C  = 4'(SETTLE);
    localparam logic [19:0] TIMEOUT_C = 20'(TIMEOUT);

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD, ST_ERR} state_t;

    logic [6:0]  seg_n, seg_q, seg_p;
    logic        dp_n, dp_q, dp_p;
    logic [5:0]  enb_n, enb_q, enb_p;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [5:0]  mask_q, mask_d;
    logic [23:0] shadow_dig_q;
    logic [5:0]  shadow_dp_q;
    logic [23:0] digits_q;
    logic [5:0]  dp_out_q;
    logic        valid_q, err_q, err_d;
    logic [19:0] idle_q;
    logic        capture;
    logic [3:0]  dec_nib;
    logic        dec_bad;
    logic        enb_zero, enb_one, enb_multi, same;

    assign seg_n = SEG_ACT_LOW ? ~i_seg : i_seg;
    assign dp_n  = SEG_ACT_LOW ? ~i_seg_dp : i_seg_dp;
    assign enb_n = ENB_ACT_LOW ? ~i_seg_enb : i_seg_enb;

    assign enb_zero  = (enb_q == 6'd0);
    assign enb_one   = $onehot(enb_q);
    assign enb_multi = !enb_zero && !enb_one;
    assign same      = ({enb_q, seg_q, dp_q} == {enb_p, seg_p, dp_p});

    // Input register plus one delayed copy used for sample-to-sample compares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            dp_q  <= 1'b0;
            enb_q <= '0;
            seg_p <= '0;
            dp_p  <= 1'b0;
            enb_p <= '0;
        end else begin
            seg_q <= seg_n;
            dp_q  <= dp_n;
            enb_q <= enb_n;
            seg_p <= seg_q;
            dp_p  <= dp_q;
            enb_p <= enb_q;
        end
    end

    // Segment pattern to nibble; unknown patterns decode to E and are flagged.
    always_comb begin
        dec_nib = 4'hE;
        dec_bad = 1'b0;
        case (seg_q)
            7'h7E: dec_nib = 4'h0;
            7'h30: dec_nib = 4'h1;
            7'h6D: dec_nib = 4'h2;
            7'h79: dec_nib = 4'h3;
            7'h33: dec_nib = 4'h4;
            7'h5B: dec_nib = 4'h5;
            7'h5F: dec_nib = 4'h6;
            7'h70: dec_nib = 4'h7;
            7'h7F: dec_nib = 4'h8;
            7'h7B: dec_nib = 4'h9;
            7'h00: dec_nib = 4'hF;
            default: dec_bad = 1'b1;
        endcase
    end

    // Next-state logic; a slot is captured on the cycle its counter reaches SETTLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enb_multi) state_d = ST_ERR;
                else if (enb_one) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            ST_SETTLE: begin
                if (enb_multi)     state_d = ST_ERR;
                else if (enb_zero) state_d = ST_IDLE;
                else if (same)     cnt_d   = cnt_q + 4'd1;
                else               cnt_d   = 4'd1;
            end
            ST_HOLD: begin
                if (!same) begin
                    if (enb_multi)     state_d = ST_ERR;
                    else if (enb_zero) state_d = ST_IDLE;
                    else begin
                        state_d = ST_SETTLE;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_ERR: begin
                if (enb_zero) state_d = ST_IDLE;
                else if (enb_one) begin
                    state_d = ST_SETTLE;
                    cnt_d   = 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Checked after the case so that SETTLE=1 captures on entry.
        if (state_d == ST_SETTLE && cnt_d >= SETTLE_C) begin
            capture = 1'b1;
            state_d = ST_HOLD;
        end
        err_d  = ((state_d == ST_ERR) && (state_q != ST_ERR)) || (capture && dec_bad);
        // Frame completion clears the mask first so a same-cycle capture counts
        // toward the next frame.
        mask_d = (mask_q == 6'h3F) ? 6'h00 : mask_q;
        if (capture) mask_d = mask_d | enb_q;
    end

    // FSM state, settle counter and error pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Shadow slots, capture mask and published frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q       <= '0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            digits_q     <= '0;
            dp_out_q     <= '0;
            valid_q      <= 1'b0;
        end else begin
            mask_q  <= mask_d;
            valid_q <= (mask_q == 6'h3F);
            if (mask_q == 6'h3F) begin
                digits_q <= shadow_dig_q;
                dp_out_q <= shadow_dp_q;
            end
            for (int i = 0; i < 6; i++) begin
                if (capture && enb_q[i]) begin
                    shadow_dig_q[i*4 +: 4] <= dec_nib;
                    shadow_dp_q[i]         <= dp_q;
                end
            end
        end
    end

    // Idle counter for stall detection, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_q <= '0;
        end else if (enb_q != enb_p) begin
            idle_q <= '0;
        end else if (idle_q != TIMEOUT_C) begin
            idle_q <= idle_q + 20'd1;
        end
    end

    assign o_digits = digits_q;
    assign o_dp     = dp_out_q;
    assign o_valid  = valid_q;
    assign o_err    = err_q;
    assign o_stall  = (idle_q == TIMEOUT_C);

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: the stimulus side pushes expected
// frames derived from the digits it scans; a monitor pops them on o_valid.
module tb_seg_scan_capture;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic        o_valid, o_err, o_stall;

    typedef struct packed {
        logic [23:0] dig;
        logic [5:0]  dp;
    } frame_t;

    frame_t exp_q[$];
    frame_t mon_f;
    int total   = 0;
    int bad     = 0;
    int err_seen = 0;
    int err_exp  = 0;

    seg_scan_capture #(
        .SETTLE(SETTLE), .TIMEOUT(TIMEOUT), .ENB_ACT_LOW(1'b0), .SEG_ACT_LOW(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_seg(i_seg), .i_seg_dp(i_seg_dp),
        .i_seg_enb(i_seg_enb), .o_digits(o_digits), .o_dp(o_dp),
        .o_valid(o_valid), .o_err(o_err), .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    // Digit to segment pattern; E stands for the illegal pattern 0x01.
    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;
            4'h3: return 7'h79;  4'h4: return 7'h33;  4'h5: return 7'h5B;
            4'h6: return 7'h5F;  4'h7: return 7'h70;  4'h8: return 7'h7F;
            4'h9: return 7'h7B;  4'hF: return 7'h00;
            default: return 7'h01;
        endcase
    endfunction

    function automatic bit legal(input logic [3:0] d);
        return (d <= 4'h9) || (d == 4'hF);
    endfunction

    // Monitor: pops one expected frame per o_valid pulse, counts o_err pulses.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_valid got digits=%h dp=%b", o_digits, o_dp);
                end else begin
                    mon_f = exp_q.pop_front();
                    if (o_digits !== mon_f.dig || o_dp !== mon_f.dp) begin
                        bad++;
                        $display("FAIL frame got digits=%h dp=%b expected digits=%h dp=%b",
                                 o_digits, o_dp, mon_f.dig, mon_f.dp);
                    end
                end
            end
            if (o_err) err_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: each slot shows its digit, illegal patterns read as E
    // and cost one error pulse each.
    task automatic push_frame(input logic [23:0] dig, input logic [5:0] dp);
        frame_t f;
        f.dp = dp;
        for (int i = 0; i < 6; i++) begin
            f.dig[i*4 +: 4] = legal(dig[i*4 +: 4]) ? dig[i*4 +: 4] : 4'hE;
            if (!legal(dig[i*4 +: 4])) err_exp++;
        end
        exp_q.push_back(f);
    endtask

    task automatic drive_slot(input int idx, input logic [3:0] d, input logic dp,
                              input int hold, input int glitch);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            i_seg_enb = 6'(1 << idx);
            i_seg     = (c < glitch) ? 7'h7F : pat(d);
            i_seg_dp  = (c < glitch) ? 1'b0 : dp;
        end
    endtask

    task automatic drive_slots(input logic [23:0] dig, input logic [5:0] dp, input int first,
                               input int last, input int lo, input int hi, input int glitch);
        for (int i = first; i <= last; i++)
            drive_slot(i, dig[i*4 +: 4], dp[i], $urandom_range(hi, lo), glitch);
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            i_seg_enb = 6'd0;
            i_seg     = 7'd0;
            i_seg_dp  = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_digits"}, 32'(o_digits), 32'h0);
        check({tag, "_dp"},     32'(o_dp),     32'h0);
        check({tag, "_valid"},  32'(o_valid),  32'h0);
        check({tag, "_err"},    32'(o_err),    32'h0);
        check({tag, "_stall"},  32'(o_stall),  32'h0);
    endtask

    initial begin
        int k;
        bit hit;
        logic [23:0] rd;
        logic [5:0]  rdp;
        logic [3:0]  v;

        rst_n = 1'b0; i_seg = '0; i_seg_dp = 1'b0; i_seg_enb = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(5);

        // Plain scan of 123456
        push_frame(24'h123456, 6'b0);
        drive_slots(24'h123456, 6'b0, 0, 5, 10, 10, 0);
        idle(10);
        check("plain_frame_seen", 32'(exp_q.size()), 32'd0);
        check("plain_err", 32'(err_seen), 32'(err_exp));
        check("plain_no_stall", 32'(o_stall), 32'd0);

        // Two-cycle 7F glitch at the start of each slot
        push_frame(24'h123456, 6'b0);
        drive_slots(24'h123456, 6'b0, 0, 5, 10, 10, 2);
        idle(10);
        check("glitch_frame_seen", 32'(exp_q.size()), 32'd0);
        check("glitch_err", 32'(err_seen), 32'(err_exp));

        // Illegal pattern on slot 3, dp on slot 0
        push_frame(24'h12E456, 6'b000001);
        drive_slots(24'h12E456, 6'b000001, 0, 5, 10, 10, 0);
        idle(10);
        check("badpat_frame_seen", 32'(exp_q.size()), 32'd0);
        check("badpat_err", 32'(err_seen), 32'(err_exp));

        // Multi-hot enable for 3 cycles mid-frame
        push_frame(24'h305918, 6'b100100);
        err_exp++;
        drive_slots(24'h305918, 6'b100100, 0, 2, 10, 10, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            i_seg_enb = 6'b000011;
            i_seg     = pat(4'h8);
            i_seg_dp  = 1'b0;
        end
        drive_slots(24'h305918, 6'b100100, 3, 5, 10, 10, 0);
        idle(10);
        check("multihot_frame_seen", 32'(exp_q.size()), 32'd0);
        check("multihot_err", 32'(err_seen), 32'(err_exp));

        // Frozen scan on slot 2
        @(negedge clk);
        i_seg_enb = 6'b000100; i_seg = pat(4'h7); i_seg_dp = 1'b0;
        k = 0; hit = 1'b0;
        while (k < 80 && !hit) begin
            @(posedge clk); #1;
            k++;
            if (o_stall) hit = 1'b1;
        end
        total++;
        if (!(hit && k >= 50 && k <= 53)) begin
            bad++;
            $display("FAIL stall_rise got cycles=%0d seen=%0d expected cycles 50..53", k, hit);
        end
        @(negedge clk);
        i_seg_enb = 6'b001000; i_seg = pat(4'h2); i_seg_dp = 1'b0;
        k = 0;
        while (k < 6 && o_stall) begin
            @(posedge clk); #1;
            k++;
        end
        total++;
        if (o_stall || k > 2) begin
            bad++;
            $display("FAIL stall_clear got cycles=%0d stall=%0d expected <=2 and 0", k, o_stall);
        end
        drive_slot(3, 4'h2, 1'b0, 10, 0);
        check("stall_err", 32'(err_seen), 32'(err_exp));

        // Partial frame (slots 0..3 captured) discarded by reset
        drive_slots(24'h444444, 6'b111111, 0, 1, 10, 10, 0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        idle(3);
        push_frame(24'h987654, 6'b0);
        drive_slots(24'h987654, 6'b0, 0, 5, 10, 10, 0);
        idle(10);
        check("reset_frame_seen", 32'(exp_q.size()), 32'd0);

        // Randomised back-to-back frames, holds down to exactly SETTLE cycles
        for (int f = 0; f < 8; f++) begin
            for (int i = 0; i < 6; i++) begin
                k = $urandom_range(11, 0);
                v = (k == 10) ? 4'hF : (k == 11) ? 4'hE : 4'(k);
                rd[i*4 +: 4] = v;
            end
            rdp = 6'($urandom_range(63, 0));
            push_frame(rd, rdp);
            drive_slots(rd, rdp, 0, 5, SETTLE, 12, 0);
        end
        idle(12);
        check("random_frames_seen", 32'(exp_q.size()), 32'd0);
        check("random_err", 32'(err_seen), 32'(err_exp));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_capture.md
Name: seg_scan_capture

Overview:
- Receive-side counterpart of the 6-digit multiplexed 7-segment scan interface (o_seg / o_seg_dp / o_seg_enb) driven by the NCO/counter display top.
- Samples the scanned segment bus, waits for each digit slot to settle, and decodes the patterns back to BCD.
- Reassembles the six digits into a frame and flags bad patterns and a stalled scan.
- Used as an on-chip readback/self-check block and as a bench monitor for display tops.

Parameters:
- SETTLE, 4, consecutive identical registered samples required before a digit slot is captured (1..15).
- TIMEOUT, 1000000, cycles without any enable change before o_stall asserts.
- ENB_ACT_LOW, 0, 1 = i_seg_enb active-low (inverted internally); 0 = active-high.
- SEG_ACT_LOW, 0, 1 = i_seg and i_seg_dp active-low (inverted internally).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_seg  in  7  segment bus, bit6=a, bit5=b … bit0=g
- i_seg_dp  in  1  decimal point of the currently enabled digit
- i_seg_enb  in  6  digit enables, bit0 = rightmost digit
- o_digits  out  24  six decoded nibbles, [3:0] = digit0 … [23:20] = digit5
- o_dp  out  6  captured decimal points per digit
- o_valid  out  1  one-cycle pulse when o_digits/o_dp update
- o_err  out  1  one-cycle pulse on invalid pattern or multi-hot enable
- o_stall  out  1  level, scan frozen for ≥ TIMEOUT cycles

Behaviour:
- Reset (async, rst_n=0): all registers cleared. o_digits=24'h000000, o_dp=0, o_valid=0, o_err=0, o_stall=0, captured-mask=0, state=IDLE. Reset mid-frame discards the partial frame.
- Input stage: i_seg, i_seg_dp, i_seg_enb are registered once after polarity normalisation. All logic below uses the registered copies.
- Decode (active-high after normalisation), value → nibble:
  - 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9
  - 00 (blank)→F
  - any other pattern → E, and the pattern is invalid.
- State machine:
  - IDLE: enable is zero-hot. Stay here. Enable one-hot → SETTLE, stable counter cleared to 1.
  - SETTLE: same enable and seg/dp as the previous sample → counter +1; any difference → counter restarts at 1. When the counter reaches SETTLE, capture the nibble and dp into shadow slot idx(enable), set mask[idx], → HOLD.
  - HOLD: wait for enable or seg to change. Change to one-hot → SETTLE (counter=1). Change to zero-hot → IDLE. Change to multi-hot → ERR.
  - ERR: o_err pulses on entry. Stay while enable is multi-hot. Then go to IDLE or SETTLE by the rules above.
  - Multi-hot seen from IDLE or SETTLE also → ERR.
- Invalid pattern: the capture still happens (nibble=E) and o_err pulses in the capture cycle.
- Frame completion:
  - The cycle after mask reaches 6'h3F: copy shadow → o_digits/o_dp, pulse o_valid, clear mask.
  - A capture in that same cycle sets its mask bit after the clear, so it counts toward the next frame.
- Re-capture of a slot already set in mask overwrites the shadow; the mask is unchanged.
- Stall detection:
  - A 20-bit idle counter increments every cycle the registered enable equals its previous value, saturating at TIMEOUT.
  - o_stall=1 while the counter equals TIMEOUT.
  - Any enable change clears the counter and o_stall in the next cycle. o_stall does not clear mask.
- Latency: a pattern held from cycle N is captured at N+SETTLE (1 input reg + SETTLE-1 compares); o_valid follows 1 cycle after the sixth capture.
- Simultaneous o_err and o_valid in one cycle is legal.

Test Plan:
- Scan digits 0..5 with enable 000001→100000, each held 10 cycles, patterns for "123456" (digit0=6) → one o_valid; o_digits=24'h123456, o_dp=0, o_err=0.
- Same scan with a 2-cycle glitch seg=7F at the start of each slot, SETTLE=4 → glitch ignored; o_digits=24'h123456.
- Slot 3 pattern 0x01, dp=1 on slot 0 → o_err one pulse; o_digits[15:12]=E, o_dp=6'b000001.
- Enable 000011 for 3 cycles mid-frame, then the normal scan resumes → o_err single pulse; the frame completes once all six slots are captured.
- Enable held at 000100 with TIMEOUT=50 → o_stall rises 50 cycles after the last change; the next enable change clears it within 2 cycles; no o_valid.
- rst_n low after 4 slots captured, then a full scan of "987654" → no o_valid from the partial frame; the next o_valid shows 24'h987654.
